// File: rtl/bcd_counter_chain.sv
// Multi-digit BCD up/down counter stepped by an internal prescaler.
// Carry/borrow ripples through all digits combinationally each step.
module bcd_counter_chain #(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 12_000_000
) (
   input  logic                  sys_clk,
   input  logic                  sys_reset,
   input  logic                  run,
   input  logic                  up,
   input  logic                  clear,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  tick,
   output logic                  wrap,
   output logic                  running
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0]       p_q, p_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic                tick_q, wrap_q, run_q;
   logic                step;
   logic                roll_d;

   assign step = run & (p_q == P_LAST);
   assign p_d  = step ? '0 : p_q + 1'b1;

   // roll_d ends high only when every digit rolled over: that is the wrap
   always_comb begin
      logic [3:0] dig;
      bcd_d  = bcd_q;
      roll_d = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         dig = bcd_q[4*i +: 4];
         if (roll_d) begin
            if (up) begin
               if (dig >= 4'd9) begin
                  bcd_d[4*i +: 4] = 4'd0;
               end else begin
                  bcd_d[4*i +: 4] = dig + 4'd1;
                  roll_d = 1'b0;
               end
            end else begin
               if (dig == 4'd0 || dig > 4'd9) begin
                  bcd_d[4*i +: 4] = 4'd9;
               end else begin
                  bcd_d[4*i +: 4] = dig - 4'd1;
                  roll_d = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         p_q    <= '0;
         bcd_q  <= '0;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
         run_q  <= 1'b0;
      end else if (clear) begin
         p_q    <= '0;
         bcd_q  <= '0;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
         run_q  <= run;
      end else begin
         run_q  <= run;
         tick_q <= step;
         wrap_q <= step & roll_d;
         if (run) begin
            p_q <= p_d;
         end
         if (step) begin
            bcd_q <= bcd_d;
         end
      end
   end

   assign bcd     = bcd_q;
   assign tick    = tick_q;
   assign wrap    = wrap_q;
   assign running = run_q;

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Directed bench for bcd_counter_chain with DIGITS=2, TICK_DIV=4.
// Each scenario task checks its own expectations inline.
module tb_bcd_counter_chain;

   logic       clk = 1'b0;
   logic       sys_reset = 1'b1;
   logic       run = 1'b0;
   logic       up = 1'b1;
   logic       clear = 1'b0;
   logic [7:0] bcd;
   logic       tick, wrap, running;

   int n_cmp = 0;
   int n_bad = 0;

   bcd_counter_chain #(.DIGITS(2), .TICK_DIV(4)) dut (
      .sys_clk   (clk),
      .sys_reset (sys_reset),
      .run       (run),
      .up        (up),
      .clear     (clear),
      .bcd       (bcd),
      .tick      (tick),
      .wrap      (wrap),
      .running   (running)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tick(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (tick) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic tick_n(input int n);
      bit ok;
      for (int i = 0; i < n; i++) begin
         wait_tick(ok);
         n_cmp++;
         if (!ok) begin
            n_bad++;
            $display("FAIL tick_timeout: got no tick, need tick within 8 cycles");
            return;
         end
      end
   endtask

   task automatic tick_until(input logic [7:0] target);
      bit ok;
      for (int i = 0; i < 200; i++) begin
         wait_tick(ok);
         if (!ok || bcd == target) break;
      end
      n_cmp++;
      if (bcd !== target) begin
         n_bad++;
         $display("FAIL reach_target: bcd=%h need %h", bcd, target);
      end
   endtask

   task automatic test_reset();
      sys_reset = 1'b1;
      run = 1'b0;
      up = 1'b1;
      clear = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_cmp++;
         if ({bcd, tick, wrap, running} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset_state: bcd=%h t=%b w=%b r=%b need 00/0/0/0",
                     bcd, tick, wrap, running);
         end
      end
   endtask

   task automatic test_first_tick();
      sys_reset = 1'b0;
      run = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         cyc();
         n_cmp++;
         if (tick !== (i == 4)) begin
            n_bad++;
            $display("FAIL first_tick_c%0d: tick=%b need %b", i, tick, i == 4);
         end
      end
      n_cmp++;
      if (bcd !== 8'h01 || running !== 1'b1) begin
         n_bad++;
         $display("FAIL first_value: bcd=%h run=%b need 01/1", bcd, running);
      end
   endtask

   task automatic test_count_up();
      tick_n(8);
      n_cmp++;
      if (bcd !== 8'h09) begin
         n_bad++;
         $display("FAIL up_09: bcd=%h need 09", bcd);
      end
      tick_n(1);
      n_cmp++;
      if (bcd !== 8'h10 || wrap !== 1'b0) begin
         n_bad++;
         $display("FAIL up_carry: bcd=%h w=%b need 10/0", bcd, wrap);
      end
      tick_n(89);
      n_cmp++;
      if (bcd !== 8'h99) begin
         n_bad++;
         $display("FAIL up_99: bcd=%h need 99", bcd);
      end
      tick_n(1);
      n_cmp++;
      if (bcd !== 8'h00 || tick !== 1'b1 || wrap !== 1'b1) begin
         n_bad++;
         $display("FAIL up_wrap: bcd=%h t=%b w=%b need 00/1/1", bcd, tick, wrap);
      end
      cyc();
      n_cmp++;
      if (tick !== 1'b0 || wrap !== 1'b0) begin
         n_bad++;
         $display("FAIL pulse_width: t=%b w=%b need 0/0", tick, wrap);
      end
   endtask

   task automatic test_count_down();
      tick_n(10);
      up = 1'b0;
      tick_n(1);
      n_cmp++;
      if (bcd !== 8'h09 || wrap !== 1'b0) begin
         n_bad++;
         $display("FAIL down_borrow: bcd=%h w=%b need 09/0", bcd, wrap);
      end
      tick_n(9);
      n_cmp++;
      if (bcd !== 8'h00) begin
         n_bad++;
         $display("FAIL down_00: bcd=%h need 00", bcd);
      end
      tick_n(1);
      n_cmp++;
      if (bcd !== 8'h99 || wrap !== 1'b1) begin
         n_bad++;
         $display("FAIL down_wrap: bcd=%h w=%b need 99/1", bcd, wrap);
      end
   endtask

   task automatic test_pause();
      cyc();
      cyc();
      run = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         n_cmp++;
         if (tick !== 1'b0 || bcd !== 8'h99 || running !== 1'b0) begin
            n_bad++;
            $display("FAIL pause_c%0d: t=%b bcd=%h r=%b need 0/99/0",
                     i, tick, bcd, running);
         end
      end
      run = 1'b1;
      cyc();
      n_cmp++;
      if (tick !== 1'b0) begin
         n_bad++;
         $display("FAIL resume_early: tick=%b need 0", tick);
      end
      cyc();
      n_cmp++;
      if (tick !== 1'b1 || bcd !== 8'h98) begin
         n_bad++;
         $display("FAIL resume_tick: t=%b bcd=%h need 1/98", tick, bcd);
      end
   endtask

   task automatic test_clear();
      up = 1'b1;
      tick_until(8'h41);
      cyc();
      cyc();
      cyc();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      n_cmp++;
      if (bcd !== 8'h00 || tick !== 1'b0 || wrap !== 1'b0) begin
         n_bad++;
         $display("FAIL clear_step: bcd=%h t=%b w=%b need 00/0/0",
                  bcd, tick, wrap);
      end
      for (int i = 1; i <= 4; i++) begin
         cyc();
         n_cmp++;
         if (tick !== (i == 4)) begin
            n_bad++;
            $display("FAIL clear_restart_c%0d: tick=%b need %b", i, tick, i == 4);
         end
      end
      n_cmp++;
      if (bcd !== 8'h01) begin
         n_bad++;
         $display("FAIL clear_next: bcd=%h need 01", bcd);
      end
   endtask

   task automatic test_reset_mid();
      tick_until(8'h57);
      cyc();
      sys_reset = 1'b1;
      cyc();
      sys_reset = 1'b0;
      n_cmp++;
      if (bcd !== 8'h00 || running !== 1'b0 || tick !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_reset: bcd=%h r=%b t=%b need 00/0/0",
                  bcd, running, tick);
      end
      for (int i = 1; i <= 4; i++) begin
         cyc();
         n_cmp++;
         if (tick !== (i == 4)) begin
            n_bad++;
            $display("FAIL reset_restart_c%0d: tick=%b need %b", i, tick, i == 4);
         end
      end
      n_cmp++;
      if (bcd !== 8'h01 || running !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_next: bcd=%h r=%b need 01/1", bcd, running);
      end
   endtask

   initial begin
      test_reset();
      test_first_tick();
      test_count_up();
      test_count_down();
      test_pause();
      test_clear();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
